// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from per-bit JK cells, with terminal count and wrap pulse.
// Define JK_COUNTER_LOAD_EN to enable the synchronous clamped parallel load.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else     q <= (j & ~q) | (~k & q);
endmodule

module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  // One extra bit so q+1 stays exact when MOD == 2^WIDTH.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] MODW = (WIDTH+1)'(MOD);

  logic [WIDTH:0]   qx, dx, nxt;
  logic [WIDTH-1:0] j, k;
  logic             ld;
  logic             unused;

  assign qx = {1'b0, q};
  assign dx = {1'b0, d};

`ifdef JK_COUNTER_LOAD_EN
  assign ld     = load;
  assign unused = nxt[WIDTH];
`else
  assign ld     = 1'b0;
  assign unused = nxt[WIDTH] ^ load ^ (^d);
`endif

  always_comb begin
    nxt = qx;
    if (ld)
      nxt = (dx < MODW) ? dx : LAST;
    else if (en) begin
      // Out-of-range counts fall back into range in either direction.
      if (up) nxt = (qx >= LAST) ? '0 : qx + 1'b1;
      else    nxt = (qx == '0 || qx >= MODW) ? LAST : qx - 1'b1;
    end
  end

  assign tc = en & ~ld & ((up & (qx == LAST)) | (~up & (qx == '0)));

  assign j = nxt[WIDTH-1:0] & ~q;
  assign k = ~nxt[WIDTH-1:0] & q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) wrap <= 1'b0;
    else     wrap <= tc;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Randomized self-checking bench for jk_mod_counter against an arithmetic model.
module tb_jk_mod_counter;
  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             rst, en, up, load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc, wrap;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int mq = 0;
  int mwrap = 0;

  jk_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic bit load_active();
`ifdef JK_COUNTER_LOAD_EN
    return load;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_tc();
    if (!en || load_active()) return 0;
    if (up)  return (mq == MOD - 1) ? 1 : 0;
    return (mq == 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain modular arithmetic
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq = 0;
      mwrap = 0;
    end else begin
      mwrap = model_tc();
      if (load_active())
        mq = (int'(d) < MOD) ? int'(d) : MOD - 1;
      else if (en)
        mq = up ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
    end
  end

  always @(negedge clk) begin
    check("q",    int'(q),    mq);
    check("wrap", int'(wrap), mwrap);
    check("tc",   int'(tc),   model_tc());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int seq_dir[4] = '{6, 5, 6, 5};

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; d = '0;
    #1;
    check("rst_tc", int'(tc), 1'b0);
    repeat (3) begin
      tick();
      check("rst_q", int'(q), 0);
      check("rst_wrap", int'(wrap), 0);
    end
    rst = 1'b0;
    tick();
    check("first_count", int'(q), 1);

    // up run from zero
    rst = 1'b1; #1; rst = 1'b0;
    check("repulse_q", int'(q), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up_q", int'(q), seq_up[i]);
      check("up_tc", int'(tc), (seq_up[i] == 9) ? 1 : 0);
      check("up_wrap", int'(wrap), (seq_up[i] == 0) ? 1 : 0);
    end

    // down through zero
    up = 1'b0;
    tick(); tick();
    check("down_q0", int'(q), 0);
    check("down_tc", int'(tc), 1);
    check("down_wrap0", int'(wrap), 0);
    tick();
    check("down_q9", int'(q), 9);
    check("down_wrap", int'(wrap), 1);
    tick();
    check("down_q8", int'(q), 8);
    check("down_wrap_end", int'(wrap), 0);

    // hold then direction toggling
    repeat (3) tick();
    check("to5", int'(q), 5);
    en = 1'b0;
    repeat (4) begin
      tick();
      check("hold", int'(q), 5);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      tick();
      check("dir", int'(q), seq_dir[i]);
    end

`ifdef JK_COUNTER_LOAD_EN
    load = 1'b1; d = 4'd7; en = 1'b1; up = 1'b1;
    #1;
    check("load_tc", int'(tc), 0);
    tick();
    check("load_q", int'(q), 7);
    check("load_wrap", int'(wrap), 0);
    d = 4'd12;
    tick();
    check("clamp_q", int'(q), 9);
    load = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1; up = 1'b0;
    repeat (3) tick();
    check("from_load", int'(q), 6);
`else
    up = 1'b1;
    tick();
    check("to6", int'(q), 6);
    load = 1'b1; d = 4'd3; en = 1'b0;
    tick();
    check("load_ignored", int'(q), 6);
    load = 1'b0; en = 1'b1;
`endif

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("async_q", int'(q), 0);
    check("async_wrap", int'(wrap), 0);
    tick();
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) == 1;
      load = ($urandom_range(0, 7) == 0);
      d    = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1; #1; rst = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
